// File: rtl/render_sched_if.sv
// Pixel coordinate handshake between the render scheduler and GEN_RAY.
// The scheduler is the master; the ray generator is the slave.
interface render_sched_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [9:0] pix_y;

  modport master (
    output pix_valid,
    output pix_x,
    output pix_y,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_x,
    input  pix_y,
    output pix_ready
  );
endinterface

// File: rtl/render_sched.sv
// Frame scheduler: camera setup, raster pixel issue with credit limit,
// drain of in-flight pixels and queuing of re-render requests.
module render_sched #(
  parameter int WIDTH        = 800,
  parameter int HEIGHT       = 600,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          req_move,
  input  logic          req_rotate,
  output logic          cam_init_start,
  input  logic          cam_init_done,
  render_sched_if.master pix,
  input  logic          retire,
  output logic [1:0]    draw_mode,
  output logic          busy,
  output logic          pending,
  output logic          frame_done,
  output logic          err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [9:0] XL = 10'(WIDTH - 1);
  localparam logic [9:0] YL = 10'(HEIGHT - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    STILL,
    INIT_CAM,
    ISSUE,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          prot_q, prot_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic [1:0]    mode_q, mode_d;

  logic valid;
  logic xfer;
  logic ret_ok;
  logic any_req;
  logic last_px;
  logic done_now;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    prot_d   = prot_q;
    mode_d   = mode_q;
    start_d  = 1'b0;
    done_now = 1'b0;

    valid   = (state_q == ISSUE) && (cnt_q != CMAX);
    xfer    = valid && pix.pix_ready;
    ret_ok  = retire && (cnt_q != '0);
    err_d   = err_q | (retire && (cnt_q == '0));
    any_req = req_move | req_rotate;
    last_px = (x_q == XL) && (y_q == YL);

    unique case (1'b1)
      xfer && !ret_ok: cnt_d = cnt_q + CW'(1);
      !xfer && ret_ok: cnt_d = cnt_q - CW'(1);
      default:         cnt_d = cnt_q;
    endcase

    unique case (state_q)
      STILL: begin
        if (any_req) begin
          state_d = INIT_CAM;
          start_d = 1'b1;
          mode_d  = req_rotate ? 2'b11 : 2'b10;
        end
      end
      INIT_CAM: begin
        if (cam_init_done) begin
          state_d = ISSUE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (last_px) begin
            state_d = DRAIN;
          end else if (x_q == XL) begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          done_now = 1'b1;
          // a request arriving in this very cycle still chains a frame
          if (pend_q || any_req) begin
            state_d = INIT_CAM;
            start_d = 1'b1;
            mode_d  = (prot_q || req_rotate) ? 2'b11 : 2'b10;
          end else begin
            state_d = STILL;
            mode_d  = 2'b00;
          end
        end
      end
      default: state_d = STILL;
    endcase

    if (start_d) begin
      pend_d = 1'b0;
      prot_d = 1'b0;
    end else if ((state_q != STILL) && any_req) begin
      pend_d = 1'b1;
      prot_d = prot_q | req_rotate;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q <= STILL;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      prot_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      prot_q  <= prot_d;
      err_q   <= err_d;
      start_q <= start_d;
      mode_q  <= mode_d;
    end
  end

  assign pix.pix_valid  = valid;
  assign pix.pix_x      = x_q;
  assign pix.pix_y      = y_q;
  assign cam_init_start = start_q;
  assign draw_mode      = mode_q;
  assign busy           = (state_q != STILL);
  assign pending        = pend_q;
  assign frame_done     = done_now && reset_n;
  assign err            = err_q;

endmodule

// File: tb/tb_render_sched.sv
// Scoreboard bench for render_sched: expected coordinates queued at frame
// start and popped on every observed transfer.
module tb_render_sched;
  localparam int W = 4;
  localparam int H = 2;
  localparam int M = 2;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_move = 1'b0;
  logic       req_rotate = 1'b0;
  logic       cam_init_done = 1'b0;
  logic       retire = 1'b0;
  logic       cam_init_start;
  logic [1:0] draw_mode;
  logic       busy, pending, frame_done, err;

  render_sched_if pif();

  render_sched #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(M)) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .req_move      (req_move),
    .req_rotate    (req_rotate),
    .cam_init_start(cam_init_start),
    .cam_init_done (cam_init_done),
    .pix           (pif.master),
    .retire        (retire),
    .draw_mode     (draw_mode),
    .busy          (busy),
    .pending       (pending),
    .frame_done    (frame_done),
    .err           (err)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [19:0] exp_q[$];
  int ret_q[$];
  bit auto_ret = 0, force_ret = 0, ready_def = 1;
  bit in_issue = 0, exp_err = 0;
  int mcnt = 0, fd_cnt = 0, rets = 0, fd_rets = 0;
  logic [9:0] stall_x = '0, stall_y = '0;
  int stall_left = 0, held = 0;

  logic s_cam, s_valid, s_busy, s_pend, s_fd, s_err;
  logic [1:0] s_mode;
  logic [9:0] s_x, s_y;

  task automatic tick();
    logic [19:0] e;
    bit xf;
    @(negedge clk_in);
    cyc++;
    retire = force_ret || (auto_ret && ret_q.size() > 0 && ret_q[0] <= cyc);
    pif.pix_ready = ready_def;
    #1;
    if (stall_left > 0 && pif.pix_valid === 1'b1 &&
        pif.pix_x == stall_x && pif.pix_y == stall_y) begin
      pif.pix_ready = 1'b0;
      stall_left--;
      held++;
    end
    #1;
    s_cam = cam_init_start; s_valid = pif.pix_valid; s_busy = busy;
    s_pend = pending; s_fd = frame_done; s_err = err;
    s_mode = draw_mode; s_x = pif.pix_x; s_y = pif.pix_y;
    xf = (s_valid === 1'b1) && (pif.pix_ready === 1'b1);
    total++;
    if (s_valid !== logic'(in_issue && mcnt < M)) begin
      bad++;
      $display("FAIL pix_valid cyc=%0d got=%b want=%b cnt=%0d",
               cyc, s_valid, (in_issue && mcnt < M), mcnt);
    end
    total++;
    if (s_err !== logic'(exp_err)) begin
      bad++;
      $display("FAIL err cyc=%0d got=%b want=%b", cyc, s_err, exp_err);
    end
    if (s_cam === 1'b1 || s_fd === 1'b1) begin
      total++;
      if (s_cam === 1'b1 && s_fd === 1'b1) begin
        bad++;
        $display("FAIL start_done_overlap cyc=%0d got=11 want=not both", cyc);
      end
    end
    if (xf) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_xfer cyc=%0d got=(%0d,%0d) want=none",
                 cyc, s_x, s_y);
      end else begin
        e = exp_q.pop_front();
        if ({s_x, s_y} !== e) begin
          bad++;
          $display("FAIL coord cyc=%0d got=(%0d,%0d) want=(%0d,%0d)",
                   cyc, s_x, s_y, e[19:10], e[9:0]);
        end
      end
      ret_q.push_back(cyc + 3);
      if (exp_q.size() == 0) in_issue = 0;
    end
    if (retire) begin
      rets++;
      if (ret_q.size() > 0) void'(ret_q.pop_front());
    end
    if (s_fd === 1'b1) begin
      fd_cnt++;
      fd_rets = rets;
    end
    if (!reset_n) begin
      mcnt = 0;
      exp_err = 0;
      ret_q.delete();
    end else begin
      if (retire && mcnt == 0) exp_err = 1;
      mcnt = mcnt + int'(xf) - int'(retire && mcnt > 0);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({10'(x), 10'(y)});
  endtask

  task automatic start_frame(input bit mv, input bit rot,
                             output logic cam, output logic [1:0] mode,
                             output logic bsy);
    push_frame();
    req_move = mv;
    req_rotate = rot;
    tick();
    req_move = 0;
    req_rotate = 0;
    tick();
    cam = s_cam; mode = s_mode; bsy = s_busy;
    cam_init_done = 1;
    tick();
    cam_init_done = 0;
    in_issue = 1;
    rets = 0;
  endtask

  task automatic wait_frame(input int maxc, output bit ok);
    int f0;
    f0 = fd_cnt;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (fd_cnt != f0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick();
    tick();
    total++; if (s_cam !== 1'b0) begin bad++; $display("FAIL rst_cam got=%b want=0", s_cam); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", s_valid); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", s_busy); end
    total++; if (s_fd !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b want=0", s_fd); end
    total++; if (s_pend !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b want=0", s_pend); end
    total++; if (s_mode !== 2'b00) begin bad++; $display("FAIL rst_mode got=%b want=00", s_mode); end
    total++; if ({s_x, s_y} !== 20'd0) begin bad++; $display("FAIL rst_xy got=(%0d,%0d) want=(0,0)", s_x, s_y); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_frame();
    logic c, b;
    logic [1:0] m;
    bit ok;
    int f0;
    auto_ret = 1;
    ready_def = 1;
    f0 = fd_cnt;
    start_frame(1, 0, c, m, b);
    total++; if (c !== 1'b1) begin bad++; $display("FAIL frame_cam got=%b want=1", c); end
    total++; if (m !== 2'b10) begin bad++; $display("FAIL frame_mode got=%b want=10", m); end
    total++; if (b !== 1'b1) begin bad++; $display("FAIL frame_busy got=%b want=1", b); end
    wait_frame(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_timeout got=no frame_done want=frame_done"); end
    total++; if (fd_rets != 8) begin bad++; $display("FAIL frame_done_retire got=%0d want=8", fd_rets); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frame_left got=%0d want=0", exp_q.size()); end
    tick();
    tick();
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL frame_idle_busy got=%b want=0", s_busy); end
    total++; if (s_mode !== 2'b00) begin bad++; $display("FAIL frame_idle_mode got=%b want=00", s_mode); end
    total++; if (fd_cnt - f0 != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", fd_cnt - f0); end
  endtask

  task automatic test_backpressure();
    logic c, b;
    logic [1:0] m;
    bit ok;
    auto_ret = 1;
    stall_x = 10'd2;
    stall_y = 10'd0;
    stall_left = 5;
    held = 0;
    start_frame(1, 0, c, m, b);
    wait_frame(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no frame_done want=frame_done"); end
    total++; if (held != 5) begin bad++; $display("FAIL bp_held got=%0d want=5", held); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left got=%0d want=0", exp_q.size()); end
    stall_left = 0;
    tick();
  endtask

  task automatic test_credit();
    logic c, b;
    logic [1:0] m;
    bit ok;
    auto_ret = 0;
    start_frame(1, 0, c, m, b);
    for (int i = 0; i < 10 && mcnt < M; i++) tick();
    tick(); tick(); tick();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL credit_stall got=%b want=0", s_valid); end
    force_ret = 1;
    tick();
    force_ret = 0;
    tick();
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL credit_reopen got=%b want=1", s_valid); end
    tick();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL credit_refull got=%b want=0", s_valid); end
    force_ret = 1;
    tick();
    tick();
    force_ret = 0;
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL credit_both got=%b want=1", s_valid); end
    tick();
    tick();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL credit_at_max got=%b want=0", s_valid); end
    auto_ret = 1;
    wait_frame(80, ok);
    total++; if (!ok) begin bad++; $display("FAIL credit_timeout got=no frame_done want=frame_done"); end
    tick();
  endtask

  task automatic test_queued();
    logic c, b;
    logic [1:0] m;
    bit ok;
    auto_ret = 1;
    start_frame(1, 0, c, m, b);
    tick(); tick();
    req_rotate = 1;
    tick();
    req_rotate = 0;
    tick();
    total++; if (s_pend !== 1'b1) begin bad++; $display("FAIL q_pending got=%b want=1", s_pend); end
    wait_frame(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL q_timeout1 got=no frame_done want=frame_done"); end
    push_frame();
    rets = 0;
    tick();
    total++; if (s_cam !== 1'b1) begin bad++; $display("FAIL q_cam got=%b want=1", s_cam); end
    total++; if (s_mode !== 2'b11) begin bad++; $display("FAIL q_mode got=%b want=11", s_mode); end
    total++; if (s_pend !== 1'b0) begin bad++; $display("FAIL q_pend_clr got=%b want=0", s_pend); end
    cam_init_done = 1;
    tick();
    cam_init_done = 0;
    in_issue = 1;
    wait_frame(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL q_timeout2 got=no frame_done want=frame_done"); end
    tick();
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL q_idle got=%b want=0", s_busy); end
  endtask

  task automatic test_both_reset();
    logic c, b;
    logic [1:0] m;
    int f0;
    auto_ret = 1;
    start_frame(1, 1, c, m, b);
    total++; if (m !== 2'b11) begin bad++; $display("FAIL both_mode got=%b want=11", m); end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_timeout got=%0d want=0", exp_q.size()); end
    auto_ret = 0;
    f0 = fd_cnt;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b want=0", s_busy); end
    total++; if (s_mode !== 2'b00) begin bad++; $display("FAIL rd_mode got=%b want=00", s_mode); end
    total++; if (s_cam !== 1'b0) begin bad++; $display("FAIL rd_cam got=%b want=0", s_cam); end
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", s_err); end
    force_ret = 1;
    tick();
    force_ret = 0;
    tick();
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL stray_err got=%b want=1", s_err); end
    tick(); tick();
    total++; if (fd_cnt != f0) begin bad++; $display("FAIL rd_no_done got=%0d want=%0d", fd_cnt, f0); end
  endtask

  initial begin
    pif.pix_ready = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_credit();
    test_queued();
    test_both_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
